// File: rtl/ex_mem_stage_pkg.sv
// Shared constants for the EX stage: ALU opcodes, forwarding-source encoding,
// and bit positions inside the MEM/WB control fields.
package ex_mem_stage_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_SLL   = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // MEM_Con = {MEMread, MEMwrite}; WB_Con = {MEMtoReg, RegWre}
    localparam int MEM_READ_BIT    = 1;
    localparam int MEM_WRITE_BIT   = 0;
    localparam int WB_MEMTOREG_BIT = 1;
    localparam int WB_REGWRE_BIT   = 0;

endpackage

// File: rtl/ex_alu.sv
// Combinational EX-stage ALU: eight operations, wrapping arithmetic,
// zero flag derived from the unregistered result.
module ex_alu
    import ex_mem_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    input  logic [2:0]    ALUCon,
    output logic [DW-1:0] Result,
    output logic          Zero
);

    always_comb begin
        Result = '0;
        case (ALUCon)
            ALU_ADD:   Result = A + B;
            ALU_SUB:   Result = A - B;
            ALU_AND:   Result = A & B;
            ALU_OR:    Result = A | B;
            ALU_XOR:   Result = A ^ B;
            ALU_SLT:   Result = {{(DW-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLL:   Result = A << B[4:0];
            ALU_PASSB: Result = B;
            default:   Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// EX stage: operand forwarding from EX/MEM and MEM/WB, ALU execution, and the
// EX/MEM pipeline register with stall (hold) and flush (bubble) control.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          Stall,
    input  logic          Flush,
    input  logic [1:0]    MEM_Con,
    input  logic [1:0]    WB_Con,
    input  logic [2:0]    ALUCon,
    input  logic          ALUSrcB,
    input  logic          RegDst,
    input  logic [RW-1:0] ID_EX_Reg_RS,
    input  logic [RW-1:0] ID_EX_Reg_RT,
    input  logic [RW-1:0] ID_EX_Reg_RD,
    input  logic [DW-1:0] ID_EX_Reg_immediate,
    input  logic [DW-1:0] ID_EX_DataBusA,
    input  logic [DW-1:0] ID_EX_DataBusB,
    input  logic          MEM_WB_RegWre,
    input  logic [RW-1:0] MEM_WB_Reg_RD,
    input  logic [DW-1:0] MEM_WB_WriteData,
    output logic [1:0]    EX_MEM_Con,
    output logic [1:0]    EX_MEM_WB_Con,
    output logic [DW-1:0] EX_MEM_ALUOut,
    output logic [DW-1:0] EX_MEM_StoreData,
    output logic [RW-1:0] EX_MEM_Reg_RD,
    output logic          EX_MEM_Zero,
    output logic          EX_MEM_Valid
);

    logic [1:0]    con_q, con_d;
    logic [1:0]    wb_con_q, wb_con_d;
    logic [DW-1:0] alu_out_q, alu_out_d;
    logic [DW-1:0] store_data_q, store_data_d;
    logic [RW-1:0] reg_rd_q, reg_rd_d;
    logic          zero_q, zero_d;
    logic          valid_q, valid_d;

    logic          exm_writes, mwb_writes;
    fwd_sel_e      fwd_a_sel, fwd_b_sel;
    logic [DW-1:0] op_a, fwd_b, op_b;
    logic [DW-1:0] alu_result;
    logic          alu_zero;

    // A load's ALUOut is an address, not the value headed for the register file.
    assign exm_writes = valid_q & wb_con_q[WB_REGWRE_BIT] & ~con_q[MEM_READ_BIT]
                        & (reg_rd_q != '0);
    assign mwb_writes = MEM_WB_RegWre & (MEM_WB_Reg_RD != '0);

    always_comb begin
        fwd_a_sel = FWD_REG;
        fwd_b_sel = FWD_REG;
        if (exm_writes && reg_rd_q == ID_EX_Reg_RS)
            fwd_a_sel = FWD_EXMEM;
        else if (mwb_writes && MEM_WB_Reg_RD == ID_EX_Reg_RS)
            fwd_a_sel = FWD_MEMWB;
        if (exm_writes && reg_rd_q == ID_EX_Reg_RT)
            fwd_b_sel = FWD_EXMEM;
        else if (mwb_writes && MEM_WB_Reg_RD == ID_EX_Reg_RT)
            fwd_b_sel = FWD_MEMWB;
    end

    always_comb begin
        op_a  = ID_EX_DataBusA;
        fwd_b = ID_EX_DataBusB;
        case (fwd_a_sel)
            FWD_EXMEM: op_a = alu_out_q;
            FWD_MEMWB: op_a = MEM_WB_WriteData;
            default:   op_a = ID_EX_DataBusA;
        endcase
        case (fwd_b_sel)
            FWD_EXMEM: fwd_b = alu_out_q;
            FWD_MEMWB: fwd_b = MEM_WB_WriteData;
            default:   fwd_b = ID_EX_DataBusB;
        endcase
    end

    assign op_b = ALUSrcB ? ID_EX_Reg_immediate : fwd_b;

    ex_alu #(.DW(DW)) u_alu (
        .A      (op_a),
        .B      (op_b),
        .ALUCon (ALUCon),
        .Result (alu_result),
        .Zero   (alu_zero)
    );

    always_comb begin
        con_d        = con_q;
        wb_con_d     = wb_con_q;
        alu_out_d    = alu_out_q;
        store_data_d = store_data_q;
        reg_rd_d     = reg_rd_q;
        zero_d       = zero_q;
        valid_d      = valid_q;
        if (Flush) begin
            con_d        = '0;
            wb_con_d     = '0;
            alu_out_d    = '0;
            store_data_d = '0;
            reg_rd_d     = '0;
            zero_d       = 1'b0;
            valid_d      = 1'b0;
        end else if (!Stall) begin
            con_d        = MEM_Con;
            wb_con_d     = WB_Con;
            alu_out_d    = alu_result;
            store_data_d = fwd_b;
            reg_rd_d     = RegDst ? ID_EX_Reg_RD : ID_EX_Reg_RT;
            zero_d       = alu_zero;
            valid_d      = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            con_q        <= '0;
            wb_con_q     <= '0;
            alu_out_q    <= '0;
            store_data_q <= '0;
            reg_rd_q     <= '0;
            zero_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            con_q        <= con_d;
            wb_con_q     <= wb_con_d;
            alu_out_q    <= alu_out_d;
            store_data_q <= store_data_d;
            reg_rd_q     <= reg_rd_d;
            zero_q       <= zero_d;
            valid_q      <= valid_d;
        end
    end

    assign EX_MEM_Con       = con_q;
    assign EX_MEM_WB_Con    = wb_con_q;
    assign EX_MEM_ALUOut    = alu_out_q;
    assign EX_MEM_StoreData = store_data_q;
    assign EX_MEM_Reg_RD    = reg_rd_q;
    assign EX_MEM_Zero      = zero_q;
    assign EX_MEM_Valid     = valid_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios followed by random traffic, all
// checked against a register-file-level reference model of the EX/MEM latch.
module tb_ex_mem_stage;
    import ex_mem_stage_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Stall, Flush;
    logic [1:0]  MEM_Con, WB_Con;
    logic [2:0]  ALUCon;
    logic        ALUSrcB, RegDst;
    logic [4:0]  RS, RT, RD;
    logic [31:0] Imm, BusA, BusB;
    logic        MEM_WB_RegWre;
    logic [4:0]  MEM_WB_Reg_RD;
    logic [31:0] MEM_WB_WriteData;
    logic [1:0]  EX_MEM_Con, EX_MEM_WB_Con;
    logic [31:0] EX_MEM_ALUOut, EX_MEM_StoreData;
    logic [4:0]  EX_MEM_Reg_RD;
    logic        EX_MEM_Zero, EX_MEM_Valid;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected contents of the EX/MEM latch
    logic [1:0]  m_con, m_wb;
    logic [31:0] m_alu, m_sd;
    logic [4:0]  m_rd;
    logic        m_zero, m_valid;

    ex_mem_stage #(.DW(32), .RW(5)) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .Stall               (Stall),
        .Flush               (Flush),
        .MEM_Con             (MEM_Con),
        .WB_Con              (WB_Con),
        .ALUCon              (ALUCon),
        .ALUSrcB             (ALUSrcB),
        .RegDst              (RegDst),
        .ID_EX_Reg_RS        (RS),
        .ID_EX_Reg_RT        (RT),
        .ID_EX_Reg_RD        (RD),
        .ID_EX_Reg_immediate (Imm),
        .ID_EX_DataBusA      (BusA),
        .ID_EX_DataBusB      (BusB),
        .MEM_WB_RegWre       (MEM_WB_RegWre),
        .MEM_WB_Reg_RD       (MEM_WB_Reg_RD),
        .MEM_WB_WriteData    (MEM_WB_WriteData),
        .EX_MEM_Con          (EX_MEM_Con),
        .EX_MEM_WB_Con       (EX_MEM_WB_Con),
        .EX_MEM_ALUOut       (EX_MEM_ALUOut),
        .EX_MEM_StoreData    (EX_MEM_StoreData),
        .EX_MEM_Reg_RD       (EX_MEM_Reg_RD),
        .EX_MEM_Zero         (EX_MEM_Zero),
        .EX_MEM_Valid        (EX_MEM_Valid)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ref_alu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: return a + b;
            3'd1: return a + (~b) + 32'd1;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return a * (32'd1 << b[4:0]);
            default: return b;
        endcase
    endfunction

    // Value the register file will hold for idx once older instructions retire
    function automatic logic [31:0] ref_fwd(logic [4:0] idx, logic [31:0] rf);
        if (m_valid && m_wb[WB_REGWRE_BIT] && !m_con[MEM_READ_BIT] && m_rd != 0 && m_rd == idx)
            return m_alu;
        if (MEM_WB_RegWre && MEM_WB_Reg_RD != 0 && MEM_WB_Reg_RD == idx)
            return MEM_WB_WriteData;
        return rf;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".con"},   {30'd0, EX_MEM_Con},    {30'd0, m_con});
        check({tag, ".wb"},    {30'd0, EX_MEM_WB_Con}, {30'd0, m_wb});
        check({tag, ".alu"},   EX_MEM_ALUOut,          m_alu);
        check({tag, ".sd"},    EX_MEM_StoreData,       m_sd);
        check({tag, ".rd"},    {27'd0, EX_MEM_Reg_RD}, {27'd0, m_rd});
        check({tag, ".zero"},  {31'd0, EX_MEM_Zero},   {31'd0, m_zero});
        check({tag, ".valid"}, {31'd0, EX_MEM_Valid},  {31'd0, m_valid});
    endtask

    task automatic model_clear();
        m_con = 0; m_wb = 0; m_alu = 0; m_sd = 0; m_rd = 0; m_zero = 0; m_valid = 0;
    endtask

    task automatic idle();
        Stall = 0; Flush = 0; MEM_Con = 0; WB_Con = 0; ALUCon = ALU_ADD;
        ALUSrcB = 0; RegDst = 1; RS = 0; RT = 0; RD = 0; Imm = 0; BusA = 0; BusB = 0;
        MEM_WB_RegWre = 0; MEM_WB_Reg_RD = 0; MEM_WB_WriteData = 0;
    endtask

    task automatic step(string tag);
        logic [31:0] a, sd, r;
        a  = ref_fwd(RS, BusA);
        sd = ref_fwd(RT, BusB);
        r  = ref_alu(ALUCon, a, ALUSrcB ? Imm : sd);
        @(posedge CLK);
        #1;
        if (Flush) begin
            model_clear();
        end else if (!Stall) begin
            m_con = MEM_Con; m_wb = WB_Con; m_alu = r; m_sd = sd;
            m_rd = RegDst ? RD : RT; m_zero = (r == 0); m_valid = 1;
        end
        check_all(tag);
    endtask

    logic [31:0] held_alu;

    initial begin
        idle();
        model_clear();
        RST = 1;
        #3;
        check_all("reset_async");
        @(posedge CLK);
        #1;
        check_all("reset_edge");
        RST = 0;

        // No forwarding: 5 - 7
        BusA = 5; BusB = 7; ALUCon = ALU_SUB; RD = 3; WB_Con = 2'b01;
        step("nofwd");
        check("nofwd_const", EX_MEM_ALUOut, 32'hFFFF_FFFE);

        // EX/MEM forward, with a competing MEM/WB write to the same register
        idle(); BusA = 10; ALUSrcB = 1; RD = 4; WB_Con = 2'b01;
        step("exm_prod");
        idle(); RS = 4; BusA = 0; ALUSrcB = 1; Imm = 1; RD = 5; WB_Con = 2'b01;
        MEM_WB_RegWre = 1; MEM_WB_Reg_RD = 4; MEM_WB_WriteData = 99;
        step("exm_fwd");
        check("exm_fwd_const", EX_MEM_ALUOut, 32'd11);

        // MEM/WB forward on the B side (store data)
        idle(); RT = 9; BusB = 1; RD = 6; MEM_WB_RegWre = 1; MEM_WB_Reg_RD = 9;
        MEM_WB_WriteData = 32'h1234;
        step("mwb_fwd");
        check("mwb_fwd_const", EX_MEM_StoreData, 32'h1234);

        // r0 is never forwarded
        idle(); BusA = 50; ALUSrcB = 1; RD = 0; WB_Con = 2'b01;
        step("r0_prod");
        idle(); RS = 0; BusA = 0; ALUSrcB = 1; RD = 7; WB_Con = 2'b01;
        step("r0_use");
        check("r0_const", EX_MEM_ALUOut, 32'd0);
        check("r0_zero", {31'd0, EX_MEM_Zero}, 32'd1);

        // Load in EX/MEM is never forwarded
        idle(); BusA = 77; ALUSrcB = 1; RD = 2; MEM_Con = 2'b10; WB_Con = 2'b11;
        step("ld_prod");
        idle(); RS = 2; BusA = 123; ALUSrcB = 1; RD = 8; WB_Con = 2'b01;
        step("ld_use");
        check("ld_const", EX_MEM_ALUOut, 32'd123);

        // Stall holds for three cycles while inputs change
        held_alu = m_alu;
        for (int i = 0; i < 3; i++) begin
            idle(); Stall = 1; BusA = $urandom; BusB = $urandom;
            RS = 5'($urandom_range(7, 0)); RD = 5'($urandom_range(31, 1));
            ALUCon = 3'($urandom_range(7, 0)); MEM_Con = 2'b11; WB_Con = 2'b11;
            step("stall");
            check("stall_const", EX_MEM_ALUOut, held_alu);
        end
        Stall = 1; Flush = 1;
        step("flush");
        check("flush_valid", {31'd0, EX_MEM_Valid}, 32'd0);

        // SLT and SLL corner cases
        idle(); BusA = 32'hFFFF_FFFF; ALUSrcB = 1; Imm = 1; ALUCon = ALU_SLT; RD = 1;
        step("slt");
        check("slt_const", EX_MEM_ALUOut, 32'd1);
        idle(); BusA = 1; ALUSrcB = 1; Imm = 31; ALUCon = ALU_SLL; RD = 1;
        step("sll");
        check("sll_const", EX_MEM_ALUOut, 32'h8000_0000);

        // Reset in the middle of a cycle clears at once
        #2 RST = 1;
        #1;
        model_clear();
        check_all("reset_mid");
        @(negedge CLK);
        RST = 0;
        idle(); BusA = 40; BusB = 2; ALUCon = ALU_ADD; RD = 12; WB_Con = 2'b01;
        step("after_reset");

        // Random traffic with a small register index space to provoke forwarding
        for (int i = 0; i < 300; i++) begin
            Stall = ($urandom_range(7, 0) == 0);
            Flush = ($urandom_range(11, 0) == 0);
            MEM_Con = 2'($urandom_range(3, 0));
            WB_Con = 2'($urandom_range(3, 0));
            ALUCon = 3'($urandom_range(7, 0));
            ALUSrcB = 1'($urandom_range(1, 0));
            RegDst = 1'($urandom_range(1, 0));
            RS = 5'($urandom_range(7, 0));
            RT = 5'($urandom_range(7, 0));
            RD = 5'($urandom_range(7, 0));
            Imm = ($urandom_range(1, 0) == 1) ? 32'($urandom_range(40, 0)) : $urandom;
            BusA = ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom;
            BusB = $urandom;
            MEM_WB_RegWre = 1'($urandom_range(1, 0));
            MEM_WB_Reg_RD = 5'($urandom_range(7, 0));
            MEM_WB_WriteData = $urandom;
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX-side consumer of the ID/EX pipeline register.
- Takes the latched ID/EX fields, resolves operand forwarding from EX/MEM and MEM/WB, and executes the 3-bit ALU operation.
- Registers the result, store data, destination register and remaining MEM/WB controls into the EX/MEM pipeline register.
- Supports pipeline hold (Stall) and bubble insertion (Flush) under hazard-unit control.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Stall  in  1  hold all EX/MEM outputs this cycle.
- Flush  in  1  load a bubble into EX/MEM.
- MEM_Con  in  2  {MEMread, MEMwrite} from ID/EX.
- WB_Con  in  2  {MEMtoReg, RegWre} from ID/EX.
- ALUCon  in  3  ALU operation from ID/EX.
- ALUSrcB  in  1  1: operand B = immediate; 0: forwarded rt data.
- RegDst  in  1  1: destination = RD; 0: destination = RT.
- ID_EX_Reg_RS, ID_EX_Reg_RT, ID_EX_Reg_RD  in  RW  register indices.
- ID_EX_Reg_immediate  in  DW  sign-extended immediate.
- ID_EX_DataBusA, ID_EX_DataBusB  in  DW  register-file read data.
- MEM_WB_RegWre  in  1  writeback enable of the instruction in WB.
- MEM_WB_Reg_RD  in  RW  writeback destination.
- MEM_WB_WriteData  in  DW  writeback value.
- EX_MEM_Con  out  2  {MEMread, MEMwrite}.
- EX_MEM_WB_Con  out  2  {MEMtoReg, RegWre}.
- EX_MEM_ALUOut  out  DW  ALU result.
- EX_MEM_StoreData  out  DW  forwarded rt data, for stores.
- EX_MEM_Reg_RD  out  RW  selected destination register.
- EX_MEM_Zero  out  1  ALU result == 0.
- EX_MEM_Valid  out  1  EX/MEM holds a real instruction.

Behaviour:
- Reset: all outputs are 0 while RST is high, independent of CLK.
- Update cadence: all outputs update only on the CLK rising edge. Latency from ID/EX inputs to EX/MEM outputs is 1 cycle.
- Forward A, first match wins:
  - EX/MEM: EX_MEM_Valid & EX_MEM_WB_Con[0] & ~EX_MEM_Con[1] & EX_MEM_Reg_RD!=0 & EX_MEM_Reg_RD==ID_EX_Reg_RS -> EX_MEM_ALUOut.
  - Else MEM/WB: MEM_WB_RegWre & MEM_WB_Reg_RD!=0 & MEM_WB_Reg_RD==RS -> MEM_WB_WriteData.
  - Else ID_EX_DataBusA.
- Forward B: same rules using ID_EX_Reg_RT and ID_EX_DataBusB; the result is the store data.
- Loads in EX/MEM are never forwarded. The hazard unit guarantees a stall for load-use, so this block performs no load-use detection.
- Operand B = ALUSrcB ? immediate : store data.
- ALUCon encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
  - 101 SLT: signed compare, result 1 or 0.
  - 110 SLL: shift A left by B[4:0].
  - 111 pass B.
- Arithmetic wraps modulo 2^DW; no overflow flag.
- Zero is computed from the ALU result before registering.
- Stall=1 & Flush=0: every output holds its value.
- Flush=1: EX_MEM_Con, EX_MEM_WB_Con and EX_MEM_Valid load 0; data outputs load 0. Flush overrides Stall when both are asserted.
- Otherwise the stage loads the new result, and EX_MEM_Valid loads 1.
- Forwarding during a Stall uses the held EX/MEM values, so the result is consistent when the stall releases.
- Reset asserted mid-operation: immediate clear; the first edge after release loads normally.

Decomposition:
- Shared package holds:
  - ALU op constants: ALU_ADD … ALU_PASSB.
  - Forward-select encoding: FWD_REG=0, FWD_EXMEM=1, FWD_MEMWB=2.
  - Bit-position constants for the MEM_Con and WB_Con fields.
- One combinational sub-module, ex_alu (A, B, ALUCon -> Result, Zero). Forwarding muxes and the pipeline register stay in ex_mem_stage.

Test Plan:
- Reset: assert RST mid-cycle with outputs nonzero -> all outputs 0 immediately; EX_MEM_Valid=0.
- No forwarding: A=5, B=7, ALUCon=001, ALUSrcB=0, RegDst=1, RD=3 -> next edge ALUOut=0xFFFFFFFE, Zero=0, Reg_RD=3, Valid=1.
- EX/MEM forward:
  - Cycle 1: ADD writing r4 = 10.
  - Cycle 2: RS=4, DataBusA=0 (stale), ADD immediate 1.
  - Required: ALUOut=11. With MEM/WB also targeting r4 with data 99, still 11 (EX/MEM priority).
- r0 and load guard: EX/MEM RegWre=1, RD=0, ALUOut=50, RS=0, DataBusA=0 -> operand A=0. Same test with an EX/MEM load to r2, RS=2, MEM/WB not matching -> DataBusA is used.
- Stall, then Flush:
  - Stall=1 for 3 cycles with changing inputs -> outputs constant.
  - Stall=1 & Flush=1 -> Valid=0, EX_MEM_Con=0, EX_MEM_WB_Con=0.
- SLT and SLL: A=0xFFFFFFFF, B=1, SLT -> 1. SLL with A=1, immediate=31 -> 0x80000000.
